// File: rtl/als_uart_reporter.sv
// Converts each 8-bit light sample to BCD with a sequential double-dabble engine, then sends it as
// ASCII over the UART register bus. Define ALS_REPORTER_CRLF_EN to append CR LF to every frame.
module als_uart_reporter #(
  parameter int unsigned POLL_MAX = 100_000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [7:0]  meas_i,
  input  logic        meas_valid_i,
  output logic        busy_o,
  output logic [11:0] bcd_o,
  output logic        bcd_valid_o,
  output logic        uart_wr_o,
  output logic        uart_reg_sel_o,
  output logic        uart_addr_o,
  output logic [31:0] uart_data_o,
  input  logic [31:0] uart_rdata_i,
  output logic [7:0]  drop_cnt_o,
  output logic        timeout_o
);

`ifdef ALS_REPORTER_CRLF_EN
  localparam logic [2:0] LastChar = 3'd4;
`else
  localparam logic [2:0] LastChar = 3'd2;
`endif
  localparam int unsigned PollW = $clog2(POLL_MAX + 2);

  typedef enum logic [2:0] {StIdle, StConv, StWrData, StWrCtrl, StPoll, StNext} state_e;

  state_e             state_q;
  logic [19:0]        sr_q;
  logic [2:0]         cnt_q;
  logic [2:0]         idx_q;
  logic [PollW-1:0]   poll_q;
  logic [11:0]        bcd_q;
  logic               bcd_valid_q;
  logic               wr_q;
  logic               sel_q;
  logic [31:0]        data_q;
  logic [7:0]         drop_q;
  logic               timeout_q;

  logic [19:0] sr_adj;
  logic [19:0] sr_shift;

  // Add-3 correction on the three BCD nibbles, then one left shift.
  always_comb begin
    sr_adj = sr_q;
    for (int i = 0; i < 3; i++) begin
      if (sr_q[8+4*i +: 4] >= 4'd5) sr_adj[8+4*i +: 4] = sr_q[8+4*i +: 4] + 4'd3;
    end
    sr_shift = {sr_adj[18:0], 1'b0};
  end

  function automatic logic [7:0] char_of(input logic [2:0] idx, input logic [11:0] bcd);
    case (idx)
      3'd0:    char_of = {4'h3, bcd[11:8]};
      3'd1:    char_of = {4'h3, bcd[7:4]};
      3'd2:    char_of = {4'h3, bcd[3:0]};
      3'd3:    char_of = 8'h0D;
      default: char_of = 8'h0A;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      poll_q      <= '0;
      bcd_q       <= '0;
      bcd_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      sel_q       <= 1'b0;
      data_q      <= '0;
      drop_q      <= '0;
      timeout_q   <= 1'b0;
    end else begin
      bcd_valid_q <= 1'b0;
      wr_q        <= 1'b0;
      sel_q       <= 1'b0;
      data_q      <= '0;
      if (meas_valid_i && state_q != StIdle && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
      unique case (state_q)
        StIdle: begin
          if (meas_valid_i) begin
            sr_q    <= {12'd0, meas_i};
            cnt_q   <= '0;
            state_q <= StConv;
          end
        end
        StConv: begin
          sr_q  <= sr_shift;
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            bcd_q       <= sr_shift[19:8];
            bcd_valid_q <= 1'b1;
            idx_q       <= '0;
            wr_q        <= 1'b1;
            sel_q       <= 1'b1;
            data_q      <= {24'd0, char_of(3'd0, sr_shift[19:8])};
            state_q     <= StWrData;
          end
        end
        StWrData: begin
          wr_q    <= 1'b1;
          data_q  <= 32'h1;
          state_q <= StWrCtrl;
        end
        StWrCtrl: begin
          poll_q  <= '0;
          state_q <= StPoll;
        end
        StPoll: begin
          // First POLL cycle ignores the busy bit: the UART may not have raised it yet.
          if (poll_q != '0 && !uart_rdata_i[0]) begin
            state_q <= StNext;
          end else if (poll_q == PollW'(POLL_MAX)) begin
            timeout_q <= 1'b1;
            state_q   <= StNext;
          end else begin
            poll_q <= poll_q + 1'b1;
          end
        end
        StNext: begin
          if (idx_q == LastChar) begin
            state_q <= StIdle;
          end else begin
            idx_q   <= idx_q + 3'd1;
            wr_q    <= 1'b1;
            sel_q   <= 1'b1;
            data_q  <= {24'd0, char_of(idx_q + 3'd1, bcd_q)};
            state_q <= StWrData;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o         = (state_q != StIdle);
  assign bcd_o          = bcd_q;
  assign bcd_valid_o    = bcd_valid_q;
  assign uart_wr_o      = wr_q;
  assign uart_reg_sel_o = sel_q;
  assign uart_addr_o    = 1'b0;
  assign uart_data_o    = data_q;
  assign drop_cnt_o     = drop_q;
  assign timeout_o      = timeout_q;

endmodule

// File: tb/tb_als_uart_reporter.sv
// Bench for als_uart_reporter: table vectors and random samples against a decimal-digit model,
// plus drop, busy-hold, poll-timeout and mid-frame reset sequences.
`timescale 1ns/1ps
module tb_als_uart_reporter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  meas, meas1;
  logic        meas_valid, meas_valid1;
  logic        busy, bcd_valid, wr, sel, addr, timeout;
  logic [11:0] bcd;
  logic [31:0] data, rdata;
  logic [7:0]  drop;
  logic        busy1, bcd_valid1, wr1, sel1, addr1, timeout1;
  logic [11:0] bcd1;
  logic [31:0] data1, rdata1;
  logic [7:0]  drop1;

  als_uart_reporter dut (
    .clk_i(clk), .rst_n_i(rst_n), .meas_i(meas), .meas_valid_i(meas_valid), .busy_o(busy),
    .bcd_o(bcd), .bcd_valid_o(bcd_valid), .uart_wr_o(wr), .uart_reg_sel_o(sel),
    .uart_addr_o(addr), .uart_data_o(data), .uart_rdata_i(rdata), .drop_cnt_o(drop),
    .timeout_o(timeout)
  );

  // Second instance with a short poll limit and a UART that never clears its busy bit.
  als_uart_reporter #(.POLL_MAX(16)) dut_to (
    .clk_i(clk), .rst_n_i(rst_n), .meas_i(meas1), .meas_valid_i(meas_valid1), .busy_o(busy1),
    .bcd_o(bcd1), .bcd_valid_o(bcd_valid1), .uart_wr_o(wr1), .uart_reg_sel_o(sel1),
    .uart_addr_o(addr1), .uart_data_o(data1), .uart_rdata_i(rdata1), .drop_cnt_o(drop1),
    .timeout_o(timeout1)
  );
  assign rdata1 = 32'h1;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  function automatic void check(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endfunction

  // UART model: busy bit rises after a send command and clears hold_len cycles later.
  int   hold_len = 3;
  int   hold_cnt = 0;
  logic ubusy = 1'b0;
  assign rdata = {31'd0, ubusy};
  always @(posedge clk) begin
    if (wr && !sel && data == 32'h1) begin
      ubusy    <= 1'b1;
      hold_cnt <= hold_len;
    end else if (hold_cnt > 0) begin
      hold_cnt <= hold_cnt - 1;
      if (hold_cnt == 1) ubusy <= 1'b0;
    end
  end

  // Write monitor for both instances.
  logic [32:0] wq[$];
  int   clear_cyc = -1;
  logic prev_ubusy = 1'b0;
  int   wr1_data_cnt = 0;
  always @(negedge clk) begin
    if (prev_ubusy && !rdata[0]) clear_cyc = cycle;
    prev_ubusy = rdata[0];
    if (wr) begin
      wq.push_back({sel, data});
      check("wr_while_uart_busy", 64'(rdata[0]), 64'd0);
      if (sel && clear_cyc >= 0) begin
        check("wr_gap_after_clear", 64'(cycle - clear_cyc >= 2), 64'd1);
        clear_cyc = -1;
      end
    end
    if (wr1 && sel1) wr1_data_cnt++;
  end

  // Reference model: decimal digits by arithmetic, frame as a character list.
  logic [7:0] exp_ch[$];
  int exp_drop = 0;

  function automatic logic [11:0] model(input int n);
    exp_ch = {};
    exp_ch.push_back(8'(48 + n / 100));
    exp_ch.push_back(8'(48 + (n / 10) % 10));
    exp_ch.push_back(8'(48 + n % 10));
`ifdef ALS_REPORTER_CRLF_EN
    exp_ch.push_back(8'h0D);
    exp_ch.push_back(8'h0A);
`endif
    return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic run_frame(input logic [7:0] n, input logic [11:0] exp_bcd, input bit dup);
    int waited;
    logic [11:0] mbcd;
    mbcd = model(int'(n));
    wq = {};
    @(negedge clk); meas = n; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    check("busy_cycle1", 64'(busy), 64'd1);
    check("bcd_valid_cycle1", 64'(bcd_valid), 64'd0);
    repeat (3) @(negedge clk);
    if (dup) begin
      meas = ~n; meas_valid = 1'b1;
      @(negedge clk); meas_valid = 1'b0;
      if (exp_drop < 255) exp_drop++;
      repeat (4) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    check("bcd_valid_cycle9", 64'(bcd_valid), 64'd1);
    check("bcd_cycle9", 64'(bcd), 64'(exp_bcd));
    check("wr_cycle9", 64'({wr, sel, data}), 64'({2'b11, 24'd0, exp_ch[0]}));
    waited = 0;
    while (busy && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("frame_done", 64'(busy), 64'd0);
    check("n_writes", 64'(wq.size()), 64'(2 * exp_ch.size()));
    for (int i = 0; i < exp_ch.size(); i++) begin
      if (2 * i + 1 < wq.size()) begin
        check("data_write", 64'(wq[2*i]), 64'({1'b1, 24'd0, exp_ch[i]}));
        check("ctrl_write", 64'(wq[2*i+1]), 64'({1'b0, 32'h1}));
      end
    end
    check("bcd_hold", 64'(bcd), 64'(mbcd));
    check("drop_cnt", 64'(drop), 64'(exp_drop));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_bcd"}, 64'({bcd, bcd_valid}), 64'd0);
    check({tag, "_uart"}, 64'({wr, sel, addr, data}), 64'd0);
    check({tag, "_drop"}, 64'(drop), 64'd0);
    check({tag, "_timeout"}, 64'(timeout), 64'd0);
  endtask

  typedef struct {
    logic [7:0]  meas;
    logic [11:0] bcd;
  } vec_t;
  vec_t vecs[8];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ctrl;
    int waited;
    logic [7:0] r;
    vecs[0] = '{8'd255, 12'h255};
    vecs[1] = '{8'd0,   12'h000};
    vecs[2] = '{8'd7,   12'h007};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd128, 12'h128};
    vecs[6] = '{8'd10,  12'h010};
    vecs[7] = '{8'd199, 12'h199};

    rst_n = 1'b0; meas = '0; meas_valid = 1'b0; meas1 = '0; meas_valid1 = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    wq = {};
    repeat (20) @(negedge clk);
    check("idle_no_writes", 64'(wq.size()), 64'd0);

    for (int i = 0; i < 8; i++) run_frame(vecs[i].meas, vecs[i].bcd, 1'b0);

    for (int i = 0; i < 25; i++) begin
      hold_len = $urandom_range(1, 6);
      r = 8'($urandom_range(0, 255));
      run_frame(r, model(int'(r)), 1'b0);
    end

    hold_len = 40;
    run_frame(8'd58, 12'h058, 1'b0);
    hold_len = 3;

    // Poll timeout on the short-limit instance.
    check("timeout_before", 64'(timeout1), 64'd0);
    wr1_data_cnt = 0;
    void'(model(77));
    @(negedge clk); meas1 = 8'd77; meas_valid1 = 1'b1;
    @(negedge clk); meas_valid1 = 1'b0;
    waited = 0;
    while (busy1 && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    check("timeout_frame_done", 64'(busy1), 64'd0);
    check("timeout_set", 64'(timeout1), 64'd1);
    check("timeout_chars_sent", 64'(wr1_data_cnt), 64'(exp_ch.size()));
    check("timeout_bcd", 64'(bcd1), 64'h077);
    check("no_timeout_main", 64'(timeout), 64'd0);

    for (int i = 0; i < 300; i++) begin
      r = 8'($urandom_range(0, 255));
      run_frame(r, model(int'(r)), 1'b1);
    end
    check("drop_saturated", 64'(drop), 64'd255);

    // Reset during the POLL of the second character.
    @(negedge clk); meas = 8'd123; meas_valid = 1'b1;
    @(negedge clk); meas_valid = 1'b0;
    n_ctrl = 0;
    waited = 0;
    while (n_ctrl < 2 && waited < 200) begin
      @(negedge clk);
      if (wr && !sel) n_ctrl++;
      waited++;
    end
    check("reached_second_ctrl", 64'(n_ctrl), 64'd2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midreset");
    wq = {};
    repeat (5) @(negedge clk);
    check("midreset_no_writes", 64'(wq.size()), 64'd0);
    rst_n = 1'b1;
    exp_drop = 0;
    repeat (5) @(negedge clk);
    check("after_release_no_writes", 64'(wq.size()), 64'd0);
    run_frame(8'd123, 12'h123, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
